// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and operation encoding for the PC / return-address stack
package pc_pkg;

  localparam int PC_D_DEFAULT     = 12;
  localparam int PC_DEPTH_DEFAULT = 4;

  // One-hot-free encoding of the winning request after priority resolution
  typedef enum logic [2:0] {
    OP_INC,
    OP_REL,
    OP_ABS,
    OP_CALL,
    OP_RET,
    OP_HOLD
  } pc_op_t;

endpackage

// File: rtl/ras_lifo.sv
// rtl/ras_lifo.sv - return-address LIFO; full pushes and empty pops are silently dropped
module ras_lifo #(
  parameter int D     = 12,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [D-1:0]  push_data,
  output logic [D-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [D-1:0]  mem_q [DEPTH];
  logic [D-1:0]  mem_d [DEPTH];
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Top-of-stack read: loop compare keeps the index width matched to the array
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i + 1) == count_q) pop_data = mem_q[i];
    end
  end

  // Next count and storage; pop wins if both arrive, though the caller never does that
  always_comb begin
    count_d = count_q;
    mem_d   = mem_q;
    if (pop && !empty) begin
      count_d = count_q - CW'(1);
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == count_q) mem_d[i] = push_data;
      end
      count_d = count_q + CW'(1);
    end
  end

  // Entry storage carries no reset; entries above the count are never read
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Occupancy register; reset discards every stacked return address
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - program counter with priority jump decode and return-address stack (optional sticky error flags via PC_RAS_ERR_EN)
module pc_ras
  import pc_pkg::*;
#(
  parameter int D     = PC_D_DEFAULT,
  parameter int DEPTH = PC_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         rel_en,
  input  logic                         abs_en,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic [D-1:0]                 target,
  output logic [D-1:0]                 prog_ctr,
  output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
  output logic                         stack_full,
  output logic                         stack_empty
`ifdef PC_RAS_ERR_EN
  ,
  output logic                         err_ovf,
  output logic                         err_unf
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  pc_op_t       op;
  logic [D-1:0] prog_ctr_q;
  logic [D-1:0] prog_ctr_d;
  logic [D-1:0] pc_plus1;
  logic [D-1:0] top_data;
  logic         do_push;
  logic         do_pop;

  assign prog_ctr = prog_ctr_q;
  assign pc_plus1 = prog_ctr_q + D'(1);
  assign do_push  = (op == OP_CALL);
  assign do_pop   = (op == OP_RET);

  ras_lifo #(
    .D     (D),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .clk       (clk),
    .reset     (reset),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (pc_plus1),
    .pop_data  (top_data),
    .count     (depth_cnt),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Priority decode: only the highest asserted request survives
  always_comb begin
    op = OP_INC;
    if (stall)        op = OP_HOLD;
    else if (ret_en)  op = OP_RET;
    else if (call_en) op = OP_CALL;
    else if (abs_en)  op = OP_ABS;
    else if (rel_en)  op = OP_REL;
  end

  // Next PC; a return on an empty stack falls through to a plain increment
  always_comb begin
    prog_ctr_d = pc_plus1;
    case (op)
      OP_HOLD: prog_ctr_d = prog_ctr_q;
      OP_RET:  prog_ctr_d = stack_empty ? pc_plus1 : top_data;
      OP_CALL: prog_ctr_d = target;
      OP_ABS:  prog_ctr_d = target;
      OP_REL:  prog_ctr_d = prog_ctr_q + target;
      default: prog_ctr_d = pc_plus1;
    endcase
  end

  // PC register
  always_ff @(posedge clk) begin
    if (reset) prog_ctr_q <= '0;
    else       prog_ctr_q <= prog_ctr_d;
  end

`ifdef PC_RAS_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_unf_q, err_unf_d;

  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

  // Sticky flags: a dropped push or an empty pop sets them until reset
  always_comb begin
    err_ovf_d = err_ovf_q | (do_push && stack_full);
    err_unf_d = err_unf_q | (do_pop && stack_empty);
  end

  // Error flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end
`endif

endmodule
